// File: rtl/droid_cmd_sequencer.sv
// droid_cmd_sequencer: command FIFO and dispatcher driving the mode, target, rank and battery registers
module droid_cmd_sequencer #(
    parameter int FIFO_DEPTH      = 4,
    parameter int BATT_SWITCH_CYC = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_opcode,
    input  logic [7:0]  cmd_data,
    input  logic [15:0] cmd_loc,
    input  logic [15:0] gps,
    output logic [1:0]  mode,
    output logic [15:0] target_loc,
    output logic [7:0]  rank,
    output logic [1:0]  batt,
    output logic        at_loc,
    output logic        busy,
    output logic        err
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = (BATT_SWITCH_CYC > 1) ? $clog2(BATT_SWITCH_CYC) : 1;
    localparam logic [3:0] OP_NOOP     = 4'b0000;
    localparam logic [3:0] OP_STANDBY  = 4'b0100;
    localparam logic [3:0] OP_ATTACK   = 4'b0101;
    localparam logic [3:0] OP_GOTO     = 4'b0110;
    localparam logic [3:0] OP_TARGET   = 4'b0111;
    localparam logic [3:0] OP_RANK     = 4'b1000;
    localparam logic [3:0] OP_BATTERY  = 4'b1001;
    localparam logic [3:0] OP_ATLOC    = 4'b1010;
    localparam logic [3:0] OP_RESET    = 4'b1100;
    localparam logic [3:0] OP_SHUTDOWN = 4'b1101;

    typedef enum logic [1:0] {IDLE = 2'd0, BATT_WAIT = 2'd1, GOTO_WAIT = 2'd2} state_t;

    state_t        state_q, state_d;
    logic [27:0]   mem [FIFO_DEPTH];
    logic [PW:0]   wr_ptr, rd_ptr;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    pend_q, pend_d;
    logic          goto_q, goto_d;
    logic [3:0]    h_op;
    logic [7:0]    h_data;
    logic [15:0]   h_loc;
    logic          empty, full, arrived, pop, do_reset, push, batt_chg;
    logic          dec_mode_v, dec_tgt_v, dec_err, dec_goto, breq_v;
    logic [1:0]    dec_mode, breq;
    logic [8:0]    rank_sum;
    logic [1:0]    mode_d, batt_d;
    logic [15:0]   tgt_d;
    logic [7:0]    rank_d;
    logic          at_loc_d, err_d;

    assign empty     = wr_ptr == rd_ptr;
    assign full      = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign {h_op, h_data, h_loc} = mem[rd_ptr[PW-1:0]];
    assign arrived   = gps == target_loc;
    assign pop       = !empty && (state_q == IDLE ||
                       (state_q == GOTO_WAIT && !arrived && (h_op == OP_SHUTDOWN || h_op == OP_RESET)));
    assign do_reset  = pop && h_op == OP_RESET;
    assign cmd_ready = !full && !do_reset;
    assign push      = cmd_valid && cmd_ready;
    assign busy      = state_q != IDLE;
    assign batt_chg  = breq_v && breq != batt;
    assign rank_sum  = {1'b0, rank} + {1'b0, h_data};

    // command storage; contents need no reset since the pointers define validity
    always_ff @(posedge clk)
        if (push) mem[wr_ptr[PW-1:0]] <= {cmd_opcode, cmd_data, cmd_loc};

    // FIFO pointers; a RESET command flushes everything still queued
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (do_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (PW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
        end

    // decode the popped command into register updates and a battery request
    always_comb begin
        dec_mode_v = 1'b0;
        dec_mode   = 2'b00;
        dec_tgt_v  = 1'b0;
        dec_err    = 1'b0;
        dec_goto   = 1'b0;
        breq_v     = 1'b0;
        breq       = 2'b00;
        if (pop)
            case (h_op)
                OP_SHUTDOWN: begin dec_mode_v = 1'b1; dec_mode = 2'b00; breq_v = 1'b1; breq = 2'b10; end
                OP_STANDBY:  begin dec_mode_v = 1'b1; dec_mode = 2'b01; breq_v = 1'b1; breq = 2'b01; end
                OP_ATTACK:   begin dec_mode_v = 1'b1; dec_mode = 2'b11; breq_v = 1'b1; breq = 2'b11; end
                OP_GOTO: begin
                    dec_mode_v = 1'b1;
                    dec_mode   = 2'b10;
                    dec_tgt_v  = 1'b1;
                    dec_goto   = 1'b1;
                    breq_v     = 1'b1;
                    breq       = 2'b01;
                end
                OP_TARGET:  dec_tgt_v = 1'b1;
                OP_BATTERY: begin
                    dec_err = h_data[1:0] == 2'b00;
                    breq_v  = h_data[1:0] != 2'b00;
                    breq    = h_data[1:0];
                end
                OP_NOOP, OP_RESET, OP_RANK, OP_ATLOC: ;
                default: dec_err = 1'b1;
            endcase
    end

    // sequencer state register with changeover bookkeeping
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pend_q  <= 2'b10;
            goto_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            goto_q  <= goto_d;
        end

    // next state: changeover wait, GOTO travel, or back to dispatching
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        goto_d  = goto_q;
        case (state_q)
            BATT_WAIT:
                if (cnt_q == '0) state_d = goto_q ? GOTO_WAIT : IDLE;
                else cnt_d = cnt_q - CW'(1);
            default:
                if (do_reset) state_d = IDLE;
                else if (batt_chg) begin
                    state_d = BATT_WAIT;
                    cnt_d   = CW'(BATT_SWITCH_CYC - 1);
                    pend_d  = breq;
                    goto_d  = dec_goto;
                end else if (dec_goto) state_d = GOTO_WAIT;
                else if (pop || arrived) state_d = IDLE;
        endcase
    end

    // next values of the architectural registers
    always_comb begin
        mode_d   = do_reset ? 2'b00 : dec_mode_v ? dec_mode : (state_q == GOTO_WAIT && arrived) ? 2'b01 : mode;
        tgt_d    = do_reset ? 16'h0000 : dec_tgt_v ? h_loc : target_loc;
        rank_d   = do_reset ? 8'd1 : (pop && h_op == OP_RANK) ? (rank_sum[8] ? 8'hFF : rank_sum[7:0]) : rank;
        batt_d   = do_reset ? 2'b10 : (state_q == BATT_WAIT && cnt_q == '0) ? pend_q : batt;
        at_loc_d = do_reset ? 1'b0 : (pop && h_op == OP_ATLOC) ? ((h_loc == 16'h0000) ? arrived : gps == h_loc) : at_loc;
        err_d    = dec_err;
    end

    // architectural output registers
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            mode       <= 2'b00;
            target_loc <= 16'h0000;
            rank       <= 8'd1;
            batt       <= 2'b10;
            at_loc     <= 1'b0;
            err        <= 1'b0;
        end else begin
            mode       <= mode_d;
            target_loc <= tgt_d;
            rank       <= rank_d;
            batt       <= batt_d;
            at_loc     <= at_loc_d;
            err        <= err_d;
        end
endmodule

// File: tb/tb_droid_cmd_sequencer.sv
// tb_droid_cmd_sequencer: directed plus random stimulus against a queue-based behavioural model
module tb_droid_cmd_sequencer;
    localparam int DEPTH = 4;
    localparam int BSW   = 3;

    typedef struct packed {
        logic [3:0]  op;
        logic [7:0]  data;
        logic [15:0] loc;
    } cmd_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_opcode = '0;
    logic [7:0]  cmd_data = '0;
    logic [15:0] cmd_loc = '0;
    logic [15:0] gps = '0;
    logic [1:0]  mode, batt;
    logic [15:0] target_loc;
    logic [7:0]  rank;
    logic        at_loc, busy, err;

    cmd_t        q[$];
    logic [1:0]  m_mode, m_batt, m_pend;
    logic [15:0] m_tgt;
    logic [7:0]  m_rank;
    bit          m_atloc, m_err, m_going, m_goto_after;
    int          m_wait;
    int          n_cmp = 0;
    int          n_bad = 0;

    droid_cmd_sequencer #(.FIFO_DEPTH(DEPTH), .BATT_SWITCH_CYC(BSW)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_opcode(cmd_opcode), .cmd_data(cmd_data), .cmd_loc(cmd_loc), .gps(gps),
        .mode(mode), .target_loc(target_loc), .rank(rank), .batt(batt),
        .at_loc(at_loc), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic void model_reset();
        q.delete();
        m_mode = 2'b00; m_tgt = '0; m_rank = 8'd1; m_batt = 2'b10; m_pend = 2'b10;
        m_atloc = 0; m_err = 0; m_going = 0; m_goto_after = 0; m_wait = 0;
    endfunction

    function automatic bit will_pop();
        if (q.size() == 0 || m_wait > 0) return 0;
        if (m_going) return (q[0].op == 4'hD || q[0].op == 4'hC) && gps != m_tgt;
        return 1;
    endfunction

    function automatic bit exp_ready();
        return q.size() < DEPTH && !(will_pop() && q[0].op == 4'hC);
    endfunction

    function automatic void batt_req(input logic [1:0] b, input bit g);
        if (b != m_batt) begin
            m_wait = BSW; m_pend = b; m_goto_after = g; m_going = 0;
        end else m_going = g;
    endfunction

    function automatic void model_edge();
        bit   pushed, popping;
        cmd_t h;
        pushed  = cmd_valid && exp_ready();
        popping = will_pop();
        m_err   = 0;
        if (m_wait > 0) begin
            m_wait--;
            if (m_wait == 0) begin m_batt = m_pend; m_going = m_goto_after; end
        end else if (m_going && !popping) begin
            if (gps == m_tgt) begin m_mode = 2'b01; m_going = 0; end
        end else if (popping) begin
            h = q.pop_front();
            m_going = 0;
            case (h.op)
                4'hC: model_reset();
                4'hD: begin m_mode = 2'b00; batt_req(2'b10, 0); end
                4'h4: begin m_mode = 2'b01; batt_req(2'b01, 0); end
                4'h5: begin m_mode = 2'b11; batt_req(2'b11, 0); end
                4'h6: begin m_tgt = h.loc; m_mode = 2'b10; batt_req(2'b01, 1); end
                4'h7: m_tgt = h.loc;
                4'h8: m_rank = (int'(m_rank) + int'(h.data) > 255) ? 8'hFF : m_rank + h.data;
                4'h9: if (h.data[1:0] == 2'b00) m_err = 1; else batt_req(h.data[1:0], 0);
                4'hA: m_atloc = (h.loc == 0) ? (gps == m_tgt) : (gps == h.loc);
                4'h0: ;
                default: m_err = 1;
            endcase
        end
        if (pushed) q.push_back('{cmd_opcode, cmd_data, cmd_loc});
    endfunction

    task automatic step(input bit r, input bit v, input logic [3:0] op, input logic [7:0] d,
                        input logic [15:0] l, input logic [15:0] g);
        rst = r; cmd_valid = v; cmd_opcode = op; cmd_data = d; cmd_loc = l; gps = g;
        if (r) model_reset();
        #4;
        check("mode", 32'(mode), 32'(m_mode));
        check("target_loc", 32'(target_loc), 32'(m_tgt));
        check("rank", 32'(rank), 32'(m_rank));
        check("batt", 32'(batt), 32'(m_batt));
        check("at_loc", 32'(at_loc), 32'(m_atloc));
        check("busy", 32'(busy), 32'(m_wait > 0 || m_going));
        check("err", 32'(err), 32'(m_err));
        check("cmd_ready", 32'(cmd_ready), 32'(exp_ready()));
        @(posedge clk);
        if (!r) model_edge();
        #1;
    endtask

    initial begin
        logic [15:0] g, l;
        logic [3:0]  op;
        int          vprob;
        model_reset();
        @(posedge clk);
        #1;
        step(1, 0, 4'h0, 8'h00, 16'h0000, 16'h0000);
        step(0, 1, 4'h5, 8'h00, 16'h0000, 16'h0000);
        for (int i = 0; i < 5; i++) step(0, 0, 4'h0, 8'h00, 16'h0000, 16'h0000);
        step(0, 1, 4'h8, 8'd200, 16'h0000, 16'h0000);
        step(0, 1, 4'h8, 8'd200, 16'h0000, 16'h0000);
        step(0, 1, 4'h6, 8'h00, 16'h1234, 16'h0000);
        for (int i = 0; i < 6; i++) step(0, i < 4, 4'h0, 8'h00, 16'h0000, 16'h0000);
        step(0, 0, 4'h0, 8'h00, 16'h0000, 16'h1234);
        step(0, 0, 4'h0, 8'h00, 16'h0000, 16'h1234);
        for (int i = 0; i < 4; i++) step(0, 0, 4'h0, 8'h00, 16'h0000, 16'h1234);
        step(0, 1, 4'hF, 8'h00, 16'h0000, 16'h1234);
        step(0, 1, 4'h9, 8'h00, 16'h0000, 16'h1234);
        step(0, 1, 4'hA, 8'h00, 16'h0000, 16'h1234);
        step(0, 1, 4'h5, 8'h00, 16'h0000, 16'h1234);
        step(0, 0, 4'h0, 8'h00, 16'h0000, 16'h1234);
        step(1, 0, 4'h0, 8'h00, 16'h0000, 16'h1234);
        vprob = 50;
        for (int n = 0; n < 4000; n++) begin
            if (n % 200 == 0) vprob = (n / 200 % 3 == 0) ? 30 : (n / 200 % 3 == 1) ? 75 : 100;
            case ($urandom_range(0, 3))
                0: g = 16'h1234;
                1, 2: g = m_tgt;
                default: g = 16'($urandom_range(0, 3));
            endcase
            case ($urandom_range(0, 3))
                0: l = 16'h0000;
                1: l = 16'h1234;
                2: l = g;
                default: l = 16'($urandom);
            endcase
            op = 4'($urandom_range(0, 15));
            if (op == 4'hC && $urandom_range(0, 3) != 0) op = 4'h6;
            step($urandom_range(0, 299) == 0, $urandom_range(0, 99) < vprob, op,
                 8'($urandom), l, g);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
